mmwave_chirp_timer: RTL
=======================

Name: mmwave_chirp_timer

Overview:
Downstream consumer of the configuration register outputs (system enable, VCO and AD-sample control fields). Generates frame/chirp timing for the VCO ramp and the ADC sample and decimation strobes feeding the DSP/UDP path. Configuration is shadowed at every frame start, so register writes during a frame never distort the frame in progress.

Parameters:
CHIRP_IDX_W, 5, width of chirp_num / chirp index
PERIOD_W, 32, width of frame period prescaler and frame counter
CHIRP_PSC_W, 16, width of chirp length prescaler
AD_PSC_W, 32, width of ADC sample prescaler
DS_PSC_W, 16, width of decimation prescaler

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sys_en_i  in  1  system enable
vco_enable_i  in  1  VCO enable
chirp_freq_psc_i  in  16  chirp length L in clk cycles (0 treated as 1)
chirp_num_i  in  5  chirps per frame N (0 treated as 1)
period_psc_i  in  32  frame period P in clk cycles (0 treated as 1)
ad_samplerate_psc_i  in  32  ADC sample interval S in clk cycles (0 treated as 1)
down_samplerate_psc_i  in  16  decimation factor D (0 treated as 1)
frame_start_o  out  1  one-cycle pulse, first cycle of a frame
chirp_start_o  out  1  one-cycle pulse, first cycle of each chirp
vco_ramp_o  out  1  high throughout every chirp
chirp_idx_o  out  5  index of current chirp, 0..N-1
adc_strobe_o  out  1  one-cycle ADC sample strobe
ds_strobe_o  out  1  one-cycle decimated-sample strobe
busy_o  out  1  high whenever state != IDLE

Behaviour:
- en = sys_en_i & vco_enable_i. All outputs are registered; on rst every output = 0, state = IDLE, all counters = 0.
- States: IDLE, CHIRP, GAP.
- IDLE: en sampled high in cycle t -> in cycle t+1: state = CHIRP, frame_start_o = chirp_start_o = vco_ramp_o = 1, chirp_idx_o = 0. Shadow registers capture L, N, P, S, D, with zero values replaced by 1.
- Frame counter starts at 0 in the frame_start cycle and increments every cycle of the frame.
- CHIRP: chirp counter runs k = 0..L-1. vco_ramp_o = 1. On k = L-1:
  - if chirp_idx < N-1: next cycle starts a new chirp (chirp_start_o = 1, chirp_idx + 1, counters cleared);
  - else if frame counter >= P-1: next cycle is a new frame (same as leaving IDLE) if en, else IDLE;
  - else: go to GAP.
- GAP: vco_ramp_o = 0 and no strobes. When frame counter = P-1: new frame next cycle if en, else IDLE.
- Frame length = max(P, N*L). Consecutive frames are back-to-back, with no idle cycle between them.
- ADC strobe: asserted in chirp cycle k when (k+1) mod S = 0. The sample counter clears at each chirp start. If S > L, the chirp produces no strobes.
- Decimation: ds_strobe_o accompanies every D-th adc_strobe_o within a chirp (the D-th, 2D-th, ...). The decimation counter clears at each chirp start.
- en low in any non-IDLE cycle -> next cycle: IDLE, all pulse/level outputs 0, chirp_idx_o = 0. The frame is aborted, not completed.
- Config inputs changing mid-frame have no effect until the next frame_start.
- chirp_idx_o holds its last value in GAP and returns to 0 in IDLE.
- Counters never wrap within a valid frame; frame counter width PERIOD_W covers the maximum P. N*L must not exceed 2^PERIOD_W-1; this is a configuration constraint and is not checked by the block.

Decomposition:
- Shared package/header mmwave_pkg: state encodings (IDLE/CHIRP/GAP), width localparams, and a macro/function for zero-to-one clamping.
- One natural sub-module, mmwave_prescaler:
  - parameterised width, synchronous clear, enable, and terminal-count input;
  - outputs a terminal pulse.
- mmwave_prescaler is instantiated for the chirp, frame, ADC sample, and decimation counters.

Test Plan:
- L=4, N=2, P=20, S=2, D=2, en rises at t:
  - frame_start at t+1 and t+21;
  - chirp_start at t+1 and t+5;
  - vco_ramp high t+1..t+8;
  - adc_strobe at t+2, t+4, t+6, t+8;
  - ds_strobe at t+4, t+8;
  - chirp_idx 0 then 1.
- L=8, N=4, P=10 (N*L > P): no GAP; frame_start every 32 cycles; busy_o stays high.
- All psc inputs = 0: L=N=P=S=D=1. frame_start, chirp_start, adc_strobe, and ds_strobe pulse every cycle; vco_ramp constantly 1.
- Drop sys_en_i at chirp 1, cycle 2 of the first scenario: next cycle all outputs 0 and IDLE. Re-raise en: fresh frame_start with chirp_idx = 0.
- Change chirp_num_i from 2 to 3 at t+10 of the first scenario: the current frame keeps 2 chirps; the frame starting at t+21 has 3 chirps.
- Assert rst mid-CHIRP: next cycle every output = 0. After release with en already high, frame_start follows 1 cycle after rst deasserts.

Source files
------------

// File: rtl/mmwave_pkg.sv
// Shared definitions for the mmWave chirp timer: FSM encoding, default widths
// and the zero-to-one clamp applied to every prescaler configuration field.
package mmwave_pkg;

    localparam int DEF_CHIRP_IDX_W = 5;
    localparam int DEF_PERIOD_W    = 32;
    localparam int DEF_CHIRP_PSC_W = 16;
    localparam int DEF_AD_PSC_W    = 32;
    localparam int DEF_DS_PSC_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHIRP = 2'd1,
        ST_GAP   = 2'd2
    } chirp_state_e;

    // A programmed count of zero behaves exactly like a count of one.
    function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/mmwave_prescaler.sv
// Wrapping up-counter with synchronous clear. tc_o flags that the value the
// counter will hold next cycle equals term_i, so callers can register strobes.
module mmwave_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == term_i) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_d == term_i);

endmodule

// File: rtl/mmwave_chirp_timer.sv
// Frame/chirp sequencer for the VCO ramp plus ADC and decimation strobes.
// Configuration is shadowed at each frame start; every output is registered.
module mmwave_chirp_timer
    import mmwave_pkg::*;
#(
    parameter int CHIRP_IDX_W = DEF_CHIRP_IDX_W,
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int CHIRP_PSC_W = DEF_CHIRP_PSC_W,
    parameter int AD_PSC_W    = DEF_AD_PSC_W,
    parameter int DS_PSC_W    = DEF_DS_PSC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sys_en_i,
    input  logic                   vco_enable_i,
    input  logic [CHIRP_PSC_W-1:0] chirp_freq_psc_i,
    input  logic [CHIRP_IDX_W-1:0] chirp_num_i,
    input  logic [PERIOD_W-1:0]    period_psc_i,
    input  logic [AD_PSC_W-1:0]    ad_samplerate_psc_i,
    input  logic [DS_PSC_W-1:0]    down_samplerate_psc_i,
    output logic                   frame_start_o,
    output logic                   chirp_start_o,
    output logic                   vco_ramp_o,
    output logic [CHIRP_IDX_W-1:0] chirp_idx_o,
    output logic                   adc_strobe_o,
    output logic                   ds_strobe_o,
    output logic                   busy_o
);

    chirp_state_e state_q, state_d;
    logic en;
    logic start_frame, start_chirp, start_any, in_chirp_d;

    logic [CHIRP_PSC_W-1:0] l_q, l_d;
    logic [CHIRP_IDX_W-1:0] n_q, n_d;
    logic [PERIOD_W-1:0]    p_q, p_d;
    logic [AD_PSC_W-1:0]    s_q, s_d;
    logic [DS_PSC_W-1:0]    d_q, d_d;

    logic chirp_last_q, frame_done_q;
    logic chirp_tc, frame_tc, sample_tc, ds_tc;

    logic [CHIRP_IDX_W-1:0] idx_q, idx_d;
    logic frame_start_q, chirp_start_q, vco_ramp_q, adc_strobe_q, ds_strobe_q, busy_q;
    logic adc_strobe_d, ds_strobe_d;

    assign en = sys_en_i & vco_enable_i;

    // Next-state logic. chirp_last_q / frame_done_q describe the current cycle.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        start_chirp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d     = ST_CHIRP;
                    start_frame = 1'b1;
                end
            end
            ST_CHIRP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (chirp_last_q) begin
                    if (idx_q < n_q - CHIRP_IDX_W'(1)) begin
                        start_chirp = 1'b1;
                    end else if (frame_done_q) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (frame_done_q) begin
                    state_d     = ST_CHIRP;
                    start_frame = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: values the registered outputs take in the next cycle.
    always_comb begin
        start_any  = start_frame | start_chirp;
        in_chirp_d = (state_d == ST_CHIRP);

        l_d = start_frame ? CHIRP_PSC_W'(clamp_to_one(32'(chirp_freq_psc_i)))      : l_q;
        n_d = start_frame ? CHIRP_IDX_W'(clamp_to_one(32'(chirp_num_i)))           : n_q;
        p_d = start_frame ? PERIOD_W'(clamp_to_one(32'(period_psc_i)))             : p_q;
        s_d = start_frame ? AD_PSC_W'(clamp_to_one(32'(ad_samplerate_psc_i)))      : s_q;
        d_d = start_frame ? DS_PSC_W'(clamp_to_one(32'(down_samplerate_psc_i)))    : d_q;

        idx_d = idx_q;
        if (start_frame || state_d == ST_IDLE) begin
            idx_d = '0;
        end else if (start_chirp) begin
            idx_d = idx_q + CHIRP_IDX_W'(1);
        end

        adc_strobe_d = in_chirp_d & sample_tc;
        ds_strobe_d  = in_chirp_d & sample_tc & ds_tc;
    end

    mmwave_prescaler #(.W(CHIRP_PSC_W)) u_chirp_cnt (
        .clk(clk), .rst(rst),
        .clr_i(start_any | ~in_chirp_d), .en_i(1'b1),
        .term_i(l_d - CHIRP_PSC_W'(1)), .tc_o(chirp_tc)
    );

    // Frame counter saturates at P-1 so long chirp trains never wrap it.
    mmwave_prescaler #(.W(PERIOD_W)) u_frame_cnt (
        .clk(clk), .rst(rst),
        .clr_i(start_frame | (state_d == ST_IDLE)), .en_i(~frame_done_q),
        .term_i(p_d - PERIOD_W'(1)), .tc_o(frame_tc)
    );

    mmwave_prescaler #(.W(AD_PSC_W)) u_sample_cnt (
        .clk(clk), .rst(rst),
        .clr_i(start_any | ~in_chirp_d), .en_i(1'b1),
        .term_i(s_d - AD_PSC_W'(1)), .tc_o(sample_tc)
    );

    // Counts ADC strobes already issued in this chirp.
    mmwave_prescaler #(.W(DS_PSC_W)) u_ds_cnt (
        .clk(clk), .rst(rst),
        .clr_i(start_any | ~in_chirp_d), .en_i(adc_strobe_q),
        .term_i(d_d - DS_PSC_W'(1)), .tc_o(ds_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            l_q           <= '0;
            n_q           <= '0;
            p_q           <= '0;
            s_q           <= '0;
            d_q           <= '0;
            chirp_last_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
            chirp_start_q <= 1'b0;
            vco_ramp_q    <= 1'b0;
            adc_strobe_q  <= 1'b0;
            ds_strobe_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            l_q           <= l_d;
            n_q           <= n_d;
            p_q           <= p_d;
            s_q           <= s_d;
            d_q           <= d_d;
            chirp_last_q  <= chirp_tc;
            frame_done_q  <= frame_tc;
            idx_q         <= idx_d;
            frame_start_q <= start_frame;
            chirp_start_q <= start_any;
            vco_ramp_q    <= in_chirp_d;
            adc_strobe_q  <= adc_strobe_d;
            ds_strobe_q   <= ds_strobe_d;
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign frame_start_o = frame_start_q;
    assign chirp_start_o = chirp_start_q;
    assign vco_ramp_o    = vco_ramp_q;
    assign chirp_idx_o   = idx_q;
    assign adc_strobe_o  = adc_strobe_q;
    assign ds_strobe_o   = ds_strobe_q;
    assign busy_o        = busy_q;

endmodule
